int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - seven-level prioritised interrupt controller with edge-detected requests
// and a nested in-service stack.
module int_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:1] irq,
   input  logic       IACK_n,
   input  logic       mask_we,
   input  logic [7:1] mask_wdata,
   input  logic       eoi,
   output logic [2:0] OINT_n,
   output logic [7:1] pending,
   output logic [7:1] isr,
   output logic       int_taken
);

   typedef enum logic [1:0] {IDLE, REQ, ACK, RELEASE} state_t;

   state_t     state;
   logic [7:1] irq_q;
   logic [7:1] mask;
   logic [2:0] isr_top;
   logic [2:0] cand;
   logic [2:0] ack_lvl;
   logic       ack;
   logic [7:1] rise;
   logic [7:1] ack_bit;
   logic [7:1] eoi_bit;

   function automatic logic [2:0] top_level(input logic [7:1] v);
      logic [2:0] lvl;
      lvl = 3'd0;
      for (int k = 1; k <= 7; k++)
         if (v[k]) lvl = 3'(k);
      return lvl;
   endfunction

   // A level is only eligible if it would nest above everything in service.
   always_comb begin
      isr_top = top_level(isr);
      cand    = top_level(pending & mask);
      if (cand <= isr_top) cand = 3'd0;
      ack     = (state == REQ) && !IACK_n;
      ack_lvl = ~OINT_n;
      rise    = irq & ~irq_q;
      ack_bit = '0;
      eoi_bit = '0;
      for (int k = 1; k <= 7; k++) begin
         ack_bit[k] = ack && (ack_lvl == 3'(k));
         eoi_bit[k] = eoi && (isr_top == 3'(k));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         OINT_n    <= 3'b111;
         pending   <= '0;
         isr       <= '0;
         irq_q     <= '0;
         mask      <= 7'h7F;
         int_taken <= 1'b0;
      end else begin
         irq_q     <= irq;
         if (mask_we) mask <= mask_wdata;
         // New edge sets after the acknowledge clear; eoi clears before the acknowledge sets.
         pending   <= (pending & ~ack_bit) | rise;
         isr       <= (isr & ~eoi_bit) | ack_bit;
         int_taken <= ack;
         case (state)
            IDLE: begin
               if (cand != 3'd0) begin
                  state  <= REQ;
                  OINT_n <= ~cand;
               end
            end
            REQ: begin
               if (ack) begin
                  state  <= ACK;
                  OINT_n <= 3'b111;
               end else if (cand == 3'd0) begin
                  state  <= IDLE;
                  OINT_n <= 3'b111;
               end else begin
                  OINT_n <= ~cand;
               end
            end
            ACK: begin
               OINT_n <= 3'b111;
               if (IACK_n) state <= RELEASE;
            end
            RELEASE: begin
               OINT_n <= 3'b111;
               state  <= IDLE;
            end
            default: begin
               OINT_n <= 3'b111;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
